// File: rtl/addsub_seq_ctrl.sv
// Sequential wide signed add/subtract built from one 4-bit slice.
// It processes one nibble per clock, LSB first, and keeps the ripple carry in a register between nibbles.
module addsub_seq_ctrl #(
  parameter  int NIBBLES = 4,
  localparam int W       = 4 * NIBBLES,
  localparam int IW      = $clog2(NIBBLES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                op,
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] result,
  output logic                c_out,
  output logic                ovf,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  carry_q, carry_d;
  logic                  op_q, op_d;
  logic signed [W-1:0]   a_q, a_d;
  logic signed [W-1:0]   b_q, b_d;
  logic signed [W-1:0]   result_q, result_d;
  logic                  c_out_q, c_out_d;
  logic                  ovf_q, ovf_d;

  logic [3:0]            nib_a;
  logic [3:0]            nib_b;
  logic [4:0]            slice;
  logic                  last;

  // The single 4-bit slice works on the nibble selected by idx.
  always_comb begin
    nib_a = a_q[{idx_q, 2'b00} +: 4];
    nib_b = b_q[{idx_q, 2'b00} +: 4] ^ {4{op_q}};
    slice = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry_q};
    last  = (idx_q == IW'(NIBBLES - 1));
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    c_out_d  = c_out_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          op_d     = op;
          // Subtracting means adding ~b + 1, so the +1 goes in as the first carry-in.
          carry_d  = op;
          idx_d    = '0;
          result_d = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        result_d[{idx_q, 2'b00} +: 4] = slice[3:0];
        carry_d = slice[4];
        if (last) begin
          idx_d   = '0;
          c_out_d = slice[4];
          ovf_d   = (a_q[W-1] == (b_q[W-1] ^ op_q)) & (slice[3] != a_q[W-1]);
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      op_q     <= 1'b0;
      result_q <= '0;
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      op_q     <= op_d;
      result_q <= result_d;
      c_out_q  <= c_out_d;
      ovf_q    <= ovf_d;
    end
  end

  // The operand latches are only read in RUN, so they need no reset.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign result    = result_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Directed bench for addsub_seq_ctrl with NIBBLES=4.
// Each scenario task drives its own stimulus and compares the outputs against hand-computed values.
module tb_addsub_seq_ctrl;
  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic                op = 1'b0;
  logic signed [W-1:0] a = '0;
  logic signed [W-1:0] b = '0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic signed [W-1:0] result;
  logic                c_out;
  logic                ovf;
  logic                busy;

  int checks = 0;
  int errors = 0;

  addsub_seq_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .c_out(c_out), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  // Presents one request from IDLE and waits a bounded number of edges for out_valid.
  // lat counts edges from the accept edge, which is counted as 1.
  task automatic run_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y, output int lat);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b, expected 1 0 0", in_ready, out_valid, busy);
    end
    checks++;
    if (result !== 16'h0000 || c_out !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: result=%h c_out=%b ovf=%b, expected 0000 0 0", result, c_out, ovf);
    end
  endtask

  task automatic test_add_latency;
    int lat;
    out_ready = 1'b1;
    op = 1'b0; a = 16'h1234; b = 16'h0FFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL add_busy: busy=%b in_ready=%b, expected 1 0", busy, in_ready);
    end
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL add_latency: %0d edges, expected 5", lat);
    end
    checks++;
    if (result !== 16'h2233 || c_out !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL add_result: result=%h c_out=%b ovf=%b, expected 2233 0 0", result, c_out, ovf);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL add_one_cycle: out_valid=%b in_ready=%b busy=%b, expected 0 1 0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_sub_and_ovf;
    int lat;
    out_ready = 1'b1;
    run_op(1'b1, 16'h0000, 16'h0001, lat);
    checks++;
    if (lat !== 5 || result !== 16'hFFFF || c_out !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL sub_borrow: lat=%0d result=%h c_out=%b ovf=%b, expected 5 ffff 0 0", lat, result, c_out, ovf);
    end
    @(posedge clk); #1;
    run_op(1'b0, 16'h7FFF, 16'h0001, lat);
    checks++;
    if (lat !== 5 || result !== 16'h8000 || c_out !== 1'b0 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL add_ovf: lat=%0d result=%h c_out=%b ovf=%b, expected 5 8000 0 1", lat, result, c_out, ovf);
    end
    @(posedge clk); #1;
    run_op(1'b1, 16'h8000, 16'h0001, lat);
    checks++;
    if (lat !== 5 || result !== 16'h7FFF || c_out !== 1'b1 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL sub_ovf: lat=%0d result=%h c_out=%b ovf=%b, expected 5 7fff 1 1", lat, result, c_out, ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    int lat;
    int bad;
    out_ready = 1'b0;
    op = 1'b0; a = 16'h1111; b = 16'h2222; in_valid = 1'b1;
    @(posedge clk); #1;
    // These distractor operands are presented during RUN and DONE and must be ignored.
    op = 1'b1; a = 16'h5555; b = 16'h0707;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      in_valid = ~in_valid;
      lat++;
    end
    checks++;
    if (lat !== 5 || result !== 16'h3333 || c_out !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL bp_result: lat=%0d result=%h c_out=%b ovf=%b, expected 5 3333 0 0", lat, result, c_out, ovf);
    end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = ~in_valid;
      a = a + 16'h0101;
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 ||
          result !== 16'h3333 || c_out !== 1'b0 || ovf !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL bp_hold: %0d unstable cycles (last result=%h out_valid=%b in_ready=%b), expected 0", bad, result, out_valid, in_ready);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b busy=%b, expected 1 0 0", in_ready, out_valid, busy);
    end
  endtask

  task automatic test_back_to_back;
    int first;
    int second;
    int got;
    logic [W-1:0] res0;
    logic [W-1:0] res1;
    logic         co1;
    first = -1; second = -1; got = 0; res0 = '0; res1 = '0; co1 = 1'b0;
    out_ready = 1'b1;
    op = 1'b0; a = 16'h0001; b = 16'h0001; in_valid = 1'b1;
    for (int e = 0; e < 16; e++) begin
      if (in_valid && in_ready) begin
        if (first < 0) first = e;
        else if (second < 0) second = e;
      end
      @(posedge clk); #1;
      if (second >= 0) in_valid = 1'b0;
      else if (first >= 0) begin
        op = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
      end
      if (out_valid) begin
        if (got == 0) res0 = result;
        else begin
          res1 = result;
          co1 = c_out;
        end
        got++;
      end
    end
    checks++;
    if (first < 0 || second - first !== 6) begin
      errors++;
      $display("FAIL b2b_interval: first=%0d second=%0d, expected spacing 6", first, second);
    end
    checks++;
    if (got !== 2 || res0 !== 16'h0002 || res1 !== 16'h0000 || co1 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_results: got=%0d r0=%h r1=%h c_out1=%b, expected 2 0002 0000 1", got, res0, res1, co1);
    end
  endtask

  task automatic test_reset_abort;
    int seen;
    int lat;
    out_ready = 1'b1;
    op = 1'b0; a = 16'h0FFF; b = 16'h0001; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== 16'h0000) begin
      errors++;
      $display("FAIL abort_state: in_ready=%b out_valid=%b busy=%b result=%h, expected 1 0 0 0000", in_ready, out_valid, busy, result);
    end
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abort_no_output: out_valid seen %0d cycles, expected 0", seen);
    end
    run_op(1'b0, 16'h0005, 16'h0003, lat);
    checks++;
    if (lat !== 5 || result !== 16'h0008 || c_out !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL abort_recover: lat=%0d result=%h c_out=%b ovf=%b, expected 5 0008 0 0", lat, result, c_out, ovf);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_add_latency;
    test_sub_and_ovf;
    test_backpressure;
    test_back_to_back;
    test_reset_abort;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
